// File: rtl/img_rect_multi.sv
// Overlays up to NUM_BOX outline/filled rectangles onto a vs/hs/de pixel stream; box config is double-buffered and swaps on vs rise.
// Latency 2 cycles on every output, 1 pixel/cycle, never stalls (no backpressure).
module img_rect_multi #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int NUM_BOX = 4,
  parameter int DW      = 24,
  parameter int CW      = 11,
  parameter int BORDER  = 5,
  localparam int IW     = (NUM_BOX > 1) ? $clog2(NUM_BOX) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vs_i,
  input  logic          hs_i,
  input  logic          de_i,
  input  logic [DW-1:0] data_i,
  input  logic          cfg_we,
  input  logic [IW-1:0] cfg_idx,
  input  logic          cfg_en,
  input  logic          cfg_fill,
  input  logic [CW-1:0] cfg_x1,
  input  logic [CW-1:0] cfg_y1,
  input  logic [CW-1:0] cfg_x2,
  input  logic [CW-1:0] cfg_y2,
  input  logic [DW-1:0] cfg_color,
  output logic          vs_o,
  output logic          hs_o,
  output logic          de_o,
  output logic [DW-1:0] data_o
);

  localparam logic [CW:0] L_BW  = (CW+1)'(BORDER);
  localparam logic [CW:0] L_BM1 = (CW+1)'(BORDER - 1);

  logic [CW-1:0] r_col, r_row;
  logic          r_vs_d;

  logic          r_p_en    [NUM_BOX];
  logic          r_p_fill  [NUM_BOX];
  logic [CW-1:0] r_p_x1    [NUM_BOX];
  logic [CW-1:0] r_p_y1    [NUM_BOX];
  logic [CW-1:0] r_p_x2    [NUM_BOX];
  logic [CW-1:0] r_p_y2    [NUM_BOX];
  logic [DW-1:0] r_p_color [NUM_BOX];
  logic          r_a_en    [NUM_BOX];
  logic          r_a_fill  [NUM_BOX];
  logic [CW-1:0] r_a_x1    [NUM_BOX];
  logic [CW-1:0] r_a_y1    [NUM_BOX];
  logic [CW-1:0] r_a_x2    [NUM_BOX];
  logic [CW-1:0] r_a_y2    [NUM_BOX];
  logic [DW-1:0] r_a_color [NUM_BOX];

  logic [NUM_BOX-1:0] w_hit, r_s1_hit;
  logic [DW-1:0]      r_s1_data, w_color;
  logic               r_s1_vs, r_s1_hs, r_s1_de;
  logic [CW:0]        w_col, w_row;
  logic               w_commit, w_wr_ok;

  assign w_commit = vs_i & ~r_vs_d;
  assign w_wr_ok  = cfg_we && (32'(cfg_idx) < NUM_BOX);
  assign w_col    = {1'b0, r_col};
  assign w_row    = {1'b0, r_row};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col  <= '0;
      r_row  <= '0;
      r_vs_d <= 1'b0;
    end else begin
      r_vs_d <= vs_i;
      if (hs_i)
        r_col <= '0;
      else if (de_i)
        r_col <= (r_col == CW'(IMG_W - 1)) ? '0 : r_col + 1'b1;
      if (vs_i)
        r_row <= '0;
      else if (de_i && r_col == CW'(IMG_W - 1) && r_row != CW'(IMG_H - 1))
        r_row <= r_row + 1'b1;
    end
  end

  // Commit reads pending before this cycle's write lands, so a write on the vs edge waits a frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_BOX; k++) begin
        r_p_en[k] <= 1'b0;  r_p_fill[k] <= 1'b0;  r_p_color[k] <= '0;
        r_p_x1[k] <= '0;    r_p_y1[k] <= '0;      r_p_x2[k] <= '0;  r_p_y2[k] <= '0;
        r_a_en[k] <= 1'b0;  r_a_fill[k] <= 1'b0;  r_a_color[k] <= '0;
        r_a_x1[k] <= '0;    r_a_y1[k] <= '0;      r_a_x2[k] <= '0;  r_a_y2[k] <= '0;
      end
    end else begin
      if (w_commit) begin
        for (int k = 0; k < NUM_BOX; k++) begin
          r_a_en[k] <= r_p_en[k];  r_a_fill[k] <= r_p_fill[k];  r_a_color[k] <= r_p_color[k];
          r_a_x1[k] <= r_p_x1[k];  r_a_y1[k] <= r_p_y1[k];
          r_a_x2[k] <= r_p_x2[k];  r_a_y2[k] <= r_p_y2[k];
        end
      end
      if (w_wr_ok) begin
        r_p_en[cfg_idx] <= cfg_en;  r_p_fill[cfg_idx] <= cfg_fill;  r_p_color[cfg_idx] <= cfg_color;
        r_p_x1[cfg_idx] <= cfg_x1;  r_p_y1[cfg_idx] <= cfg_y1;
        r_p_x2[cfg_idx] <= cfg_x2;  r_p_y2[cfg_idx] <= cfg_y2;
      end
    end
  end

  // Upper inner bound uses col < x2 so x2 = 0 cannot underflow into a huge inner region.
  for (genvar g = 0; g < NUM_BOX; g++) begin : g_box
    logic [CW:0] w_x1, w_x2, w_y1, w_y2;
    logic        w_vld, w_outer, w_inner;
    assign w_x1    = {1'b0, r_a_x1[g]};
    assign w_x2    = {1'b0, r_a_x2[g]};
    assign w_y1    = {1'b0, r_a_y1[g]};
    assign w_y2    = {1'b0, r_a_y2[g]};
    assign w_vld   = r_a_en[g] && (w_x1 <= w_x2) && (w_y1 <= w_y2);
    assign w_outer = (w_col >= w_x1) && (w_col <= w_x2 + L_BM1) &&
                     (w_row >= w_y1) && (w_row <= w_y2 + L_BM1);
    assign w_inner = (w_col >= w_x1 + L_BW) && (w_col < w_x2) &&
                     (w_row >= w_y1 + L_BW) && (w_row < w_y2);
    assign w_hit[g] = w_vld && w_outer && (r_a_fill[g] || !w_inner);
  end

  always_comb begin
    w_color = r_s1_data;
    for (int k = NUM_BOX - 1; k >= 0; k--)
      if (r_s1_hit[k]) w_color = r_a_color[k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vs <= 1'b0;  r_s1_hs <= 1'b0;  r_s1_de <= 1'b0;
      r_s1_data <= '0;  r_s1_hit <= '0;
      vs_o <= 1'b0;  hs_o <= 1'b0;  de_o <= 1'b0;  data_o <= '0;
    end else begin
      r_s1_vs   <= vs_i;
      r_s1_hs   <= hs_i;
      r_s1_de   <= de_i;
      r_s1_data <= data_i;
      r_s1_hit  <= w_hit & {NUM_BOX{de_i}};
      vs_o      <= r_s1_vs;
      hs_o      <= r_s1_hs;
      de_o      <= r_s1_de;
      data_o    <= w_color;
    end
  end

endmodule

// File: tb/tb_img_rect_multi.sv
// Randomised-data bench for img_rect_multi on a small 40x30 image, scored against a rectangle-geometry model.
`timescale 1ns/1ps
module tb_img_rect_multi;
  localparam int TW = 40, TH = 30, NB = 3, BD = 5;
  localparam logic [23:0] RED = 24'hFF0000, GRN = 24'h00FF00, BLU = 24'h0000FF;

  typedef struct { logic vs, hs, de; logic [23:0] data; int x, y; logic [23:0] raw; } exp_t;
  typedef struct { logic vs, hs, de; logic [23:0] data; } act_t;
  typedef struct { logic en, fill; int x1, y1, x2, y2; logic [23:0] color; } box_t;

  logic clk = 1'b0;
  logic rst, vs_i, hs_i, de_i, cfg_we, cfg_en, cfg_fill, vs_o, hs_o, de_o;
  logic [23:0] data_i, cfg_color, data_o;
  logic [1:0] cfg_idx;
  logic [10:0] cfg_x1, cfg_y1, cfg_x2, cfg_y2;

  int n_vec, n_err;
  exp_t chk_exp[$];
  act_t chk_act[$];
  exp_t prev_exp;
  box_t m_pend[NB], m_act[NB];
  logic m_vs_prev;
  bit   wr_flag, sched_vs;
  int   wr_idx, sched_row;
  box_t wr_box;

  img_rect_multi #(.IMG_W(TW), .IMG_H(TH), .NUM_BOX(NB), .DW(24), .CW(11), .BORDER(BD)) dut (
    .clk(clk), .rst(rst), .vs_i(vs_i), .hs_i(hs_i), .de_i(de_i), .data_i(data_i),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_fill(cfg_fill),
    .cfg_x1(cfg_x1), .cfg_y1(cfg_y1), .cfg_x2(cfg_x2), .cfg_y2(cfg_y2), .cfg_color(cfg_color),
    .vs_o(vs_o), .hs_o(hs_o), .de_o(de_o), .data_o(data_o));

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  function automatic logic [23:0] rnd();
    return 24'($urandom) & 24'h7F7F7F;
  endfunction

  function automatic box_t mk(input logic en, fill, input int x1, y1, x2, y2, input logic [23:0] c);
    box_t b;
    b.en = en; b.fill = fill; b.x1 = x1; b.y1 = y1; b.x2 = x2; b.y2 = y2; b.color = c;
    return b;
  endfunction

  // Geometry from the box definition: lowest valid box whose border/fill region covers (x,y).
  function automatic logic [23:0] model_pix(input int x, y, input logic [23:0] dat);
    for (int k = 0; k < NB; k++) begin
      box_t b = m_act[k];
      bit outer, inner;
      if (b.en && b.x1 <= b.x2 && b.y1 <= b.y2) begin
        outer = x >= b.x1 && x <= b.x2 + BD - 1 && y >= b.y1 && y <= b.y2 + BD - 1;
        inner = x >= b.x1 + BD && x <= b.x2 - 1 && y >= b.y1 + BD && y <= b.y2 - 1;
        if (outer && (b.fill || !inner)) return b.color;
      end
    end
    return dat;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NB; k++) begin
      m_pend[k] = mk(0, 0, 0, 0, 0, 0, 24'h0);
      m_act[k]  = mk(0, 0, 0, 0, 0, 0, 24'h0);
    end
    m_vs_prev = 1'b0;
    prev_exp.vs = 0; prev_exp.hs = 0; prev_exp.de = 0; prev_exp.data = '0;
    prev_exp.x = -1; prev_exp.y = -1; prev_exp.raw = '0;
    chk_act.delete(); chk_exp.delete();
  endtask

  task automatic cyc(input logic v, h, d, input logic [23:0] dat, input int x, y);
    exp_t e;
    act_t a;
    vs_i = v; hs_i = h; de_i = d; data_i = dat;
    cfg_we = wr_flag;
    if (wr_flag) begin
      cfg_idx = 2'(wr_idx); cfg_en = wr_box.en; cfg_fill = wr_box.fill; cfg_color = wr_box.color;
      cfg_x1 = 11'(wr_box.x1); cfg_y1 = 11'(wr_box.y1); cfg_x2 = 11'(wr_box.x2); cfg_y2 = 11'(wr_box.y2);
    end else begin
      cfg_idx = 2'($urandom); cfg_en = 1'($urandom); cfg_fill = 1'($urandom); cfg_color = 24'($urandom);
      cfg_x1 = 11'($urandom_range(0, 20)); cfg_y1 = 11'($urandom_range(0, 20));
      cfg_x2 = 11'($urandom_range(0, 40)); cfg_y2 = 11'($urandom_range(0, 30));
    end
    e.vs = v; e.hs = h; e.de = d; e.x = x; e.y = y; e.raw = dat;
    e.data = d ? model_pix(x, y, dat) : dat;
    if (v && !m_vs_prev) for (int k = 0; k < NB; k++) m_act[k] = m_pend[k];
    m_vs_prev = v;
    if (wr_flag && wr_idx < NB) m_pend[wr_idx] = wr_box;
    wr_flag = 0;
    @(posedge clk); #1;
    a.vs = vs_o; a.hs = hs_o; a.de = de_o; a.data = data_o;
    chk_act.push_back(a);
    chk_exp.push_back(prev_exp);
    prev_exp = e;
  endtask

  task automatic stage_box(input int idx, input box_t b);
    wr_idx = idx; wr_box = b;
  endtask

  task automatic write_box(input int idx, input box_t b);
    stage_box(idx, b);
    wr_flag = 1;
    cyc(0, 0, 0, rnd(), -1, -1);
  endtask

  task automatic clear_boxes();
    for (int k = 0; k < NB; k++) write_box(k, mk(0, 0, 0, 0, 0, 0, 24'h0));
  endtask

  task automatic frame(input bit use_hs, input int nlines);
    for (int i = 0; i < 2; i++) begin
      if (i == 0 && sched_vs) begin wr_flag = 1; sched_vs = 0; end
      cyc(1, 0, 0, rnd(), -1, -1);
    end
    for (int y = 0; y < nlines; y++) begin
      if (use_hs) cyc(0, 1, 0, rnd(), -1, -1);
      for (int x = 0; x < TW; x++) begin
        if (y == sched_row && x == 5) begin wr_flag = 1; sched_row = -1; end
        cyc(0, 0, 1, rnd(), x, (y < TH) ? y : TH - 1);
      end
    end
    cyc(0, 0, 0, rnd(), -1, -1);
  endtask

  task automatic test_reset();
    rst = 1; vs_i = 1; hs_i = 1; de_i = 1; data_i = rnd(); cfg_we = 0;
    cfg_idx = 0; cfg_en = 0; cfg_fill = 0; cfg_color = 0; cfg_x1 = 0; cfg_y1 = 0; cfg_x2 = 0; cfg_y2 = 0;
    @(posedge clk); #1; @(posedge clk); #1;
    n_vec++;
    if ({vs_o, hs_o, de_o, data_o} !== 27'h0) begin
      n_err++; $display("FAIL reset_outputs got %07h want 0000000", {vs_o, hs_o, de_o, data_o});
    end
    rst = 0;
    model_reset();
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, rnd(), -1, -1);
    cyc(0, 0, 1, rnd(), 0, 0);
    cyc(0, 0, 0, rnd(), -1, -1);
    while (chk_act.size() > 0) begin
      act_t a = chk_act.pop_front();
      exp_t e = chk_exp.pop_front();
      n_vec++;
      if ({a.vs, a.hs, a.de, a.data} !== {e.vs, e.hs, e.de, e.data}) begin
        n_err++; $display("FAIL post_reset got %07h want %07h", {a.vs, a.hs, a.de, a.data}, {e.vs, e.hs, e.de, e.data});
      end
    end
  endtask

  task automatic test_outline();
    int nr = 0;
    clear_boxes();
    write_box(0, mk(1, 0, 10, 10, 20, 20, RED));
    frame(1, TH);
    while (chk_act.size() > 0) begin
      act_t a = chk_act.pop_front();
      exp_t e = chk_exp.pop_front();
      n_vec++;
      if ({a.vs, a.hs, a.de, a.data} !== {e.vs, e.hs, e.de, e.data}) begin
        n_err++; $display("FAIL outline px(%0d,%0d) got %07h want %07h", e.x, e.y, {a.vs, a.hs, a.de, a.data}, {e.vs, e.hs, e.de, e.data});
      end
      if (e.de === 1'b1 && ((e.y == 15 && (e.x == 15 || e.x == 19)) || (e.x == 25 && e.y == 10))) begin
        n_vec++;
        if (a.data !== e.raw) begin
          n_err++; $display("FAIL outline_passthru px(%0d,%0d) got %06h want %06h", e.x, e.y, a.data, e.raw);
        end
      end
      if (a.de === 1'b1 && a.data === RED) nr++;
    end
    n_vec++;
    if (nr != 200) begin n_err++; $display("FAIL outline_count got %0d want 200", nr); end
  endtask

  task automatic test_fill();
    int ng = 0, nb = 0;
    clear_boxes();
    write_box(1, mk(1, 1, 0, 0, 3, 3, GRN));
    write_box(2, mk(1, 0, 30, 2, 32, 8, BLU));
    frame(1, TH);
    while (chk_act.size() > 0) begin
      act_t a = chk_act.pop_front();
      exp_t e = chk_exp.pop_front();
      n_vec++;
      if ({a.vs, a.hs, a.de, a.data} !== {e.vs, e.hs, e.de, e.data}) begin
        n_err++; $display("FAIL fill px(%0d,%0d) got %07h want %07h", e.x, e.y, {a.vs, a.hs, a.de, a.data}, {e.vs, e.hs, e.de, e.data});
      end
      if (a.de === 1'b1 && a.data === GRN) ng++;
      if (a.de === 1'b1 && a.data === BLU) nb++;
    end
    n_vec += 2;
    if (ng != 64) begin n_err++; $display("FAIL fill_count got %0d want 64", ng); end
    if (nb != 77) begin n_err++; $display("FAIL narrow_outline_count got %0d want 77", nb); end
  endtask

  task automatic test_overlap();
    int want_r[2] = '{90, 0};
    int want_b[2] = '{0, 90};
    clear_boxes();
    write_box(0, mk(1, 0, 30, 15, 34, 20, RED));
    write_box(2, mk(1, 0, 30, 15, 34, 20, BLU));
    for (int f = 0; f < 2; f++) begin
      int nr = 0, nb = 0;
      if (f == 1) write_box(0, mk(0, 0, 30, 15, 34, 20, RED));
      frame(1, TH);
      while (chk_act.size() > 0) begin
        act_t a = chk_act.pop_front();
        exp_t e = chk_exp.pop_front();
        n_vec++;
        if ({a.vs, a.hs, a.de, a.data} !== {e.vs, e.hs, e.de, e.data}) begin
          n_err++; $display("FAIL overlap px(%0d,%0d) got %07h want %07h", e.x, e.y, {a.vs, a.hs, a.de, a.data}, {e.vs, e.hs, e.de, e.data});
        end
        if (a.de === 1'b1 && a.data === RED) nr++;
        if (a.de === 1'b1 && a.data === BLU) nb++;
      end
      n_vec += 2;
      if (nr != want_r[f]) begin n_err++; $display("FAIL overlap_red f%0d got %0d want %0d", f, nr, want_r[f]); end
      if (nb != want_b[f]) begin n_err++; $display("FAIL overlap_blue f%0d got %0d want %0d", f, nb, want_b[f]); end
    end
  endtask

  task automatic test_double_buffer();
    int want_r[4] = '{0, 81, 81, 0};
    for (int f = 0; f < 4; f++) begin
      int nr = 0, nb = 0;
      if (f == 0) begin stage_box(0, mk(1, 1, 2, 2, 6, 6, RED)); sched_row = 12; end
      if (f == 2) begin stage_box(0, mk(0, 1, 2, 2, 6, 6, RED)); sched_vs = 1; end
      frame(1, TH);
      while (chk_act.size() > 0) begin
        act_t a = chk_act.pop_front();
        exp_t e = chk_exp.pop_front();
        n_vec++;
        if ({a.vs, a.hs, a.de, a.data} !== {e.vs, e.hs, e.de, e.data}) begin
          n_err++; $display("FAIL dbuf px(%0d,%0d) got %07h want %07h", e.x, e.y, {a.vs, a.hs, a.de, a.data}, {e.vs, e.hs, e.de, e.data});
        end
        if (a.de === 1'b1 && a.data === RED) nr++;
        if (a.de === 1'b1 && a.data === BLU) nb++;
      end
      n_vec += 2;
      if (nr != want_r[f]) begin n_err++; $display("FAIL dbuf_red f%0d got %0d want %0d", f, nr, want_r[f]); end
      if (nb != 90) begin n_err++; $display("FAIL dbuf_blue f%0d got %0d want 90", f, nb); end
    end
  endtask

  task automatic test_edges();
    int nr = 0, ng = 0, nb = 0;
    clear_boxes();
    write_box(0, mk(1, 0, 20, 5, 10, 8, RED));
    write_box(1, mk(1, 1, TW - 2, TH - 2, TW - 1, TH - 1, GRN));
    write_box(3, mk(1, 1, 0, 0, TW - 1, TH - 1, BLU));
    frame(1, TH);
    while (chk_act.size() > 0) begin
      act_t a = chk_act.pop_front();
      exp_t e = chk_exp.pop_front();
      n_vec++;
      if ({a.vs, a.hs, a.de, a.data} !== {e.vs, e.hs, e.de, e.data}) begin
        n_err++; $display("FAIL edges px(%0d,%0d) got %07h want %07h", e.x, e.y, {a.vs, a.hs, a.de, a.data}, {e.vs, e.hs, e.de, e.data});
      end
      if (a.de === 1'b1 && a.data === RED) nr++;
      if (a.de === 1'b1 && a.data === GRN) ng++;
      if (a.de === 1'b1 && a.data === BLU) nb++;
    end
    n_vec += 3;
    if (nr != 0) begin n_err++; $display("FAIL inverted_box got %0d want 0", nr); end
    if (ng != 4) begin n_err++; $display("FAIL clip_count got %0d want 4", ng); end
    if (nb != 0) begin n_err++; $display("FAIL bad_index got %0d want 0", nb); end
  endtask

  task automatic test_reset_mid();
    int want_r[2] = '{0, 36};
    clear_boxes();
    write_box(0, mk(1, 1, 0, 0, TW - 1, TH - 1, RED));
    cyc(1, 0, 0, rnd(), -1, -1);
    cyc(1, 0, 0, rnd(), -1, -1);
    cyc(0, 1, 0, rnd(), -1, -1);
    for (int x = 0; x < 10; x++) cyc(0, 0, 1, rnd(), x, 0);
    while (chk_act.size() > 0) begin
      act_t a = chk_act.pop_front();
      exp_t e = chk_exp.pop_front();
      n_vec++;
      if ({a.vs, a.hs, a.de, a.data} !== {e.vs, e.hs, e.de, e.data}) begin
        n_err++; $display("FAIL pre_reset px(%0d,%0d) got %07h want %07h", e.x, e.y, {a.vs, a.hs, a.de, a.data}, {e.vs, e.hs, e.de, e.data});
      end
    end
    rst = 1; vs_i = 0; hs_i = 0; de_i = 1; data_i = rnd(); cfg_we = 0;
    @(posedge clk); #1;
    n_vec++;
    if ({vs_o, hs_o, de_o, data_o} !== 27'h0) begin
      n_err++; $display("FAIL midline_reset got %07h want 0000000", {vs_o, hs_o, de_o, data_o});
    end
    rst = 0;
    model_reset();
    for (int f = 0; f < 2; f++) begin
      int nr = 0;
      if (f == 1) write_box(0, mk(1, 1, 5, 5, 6, 6, RED));
      frame(1, TH);
      while (chk_act.size() > 0) begin
        act_t a = chk_act.pop_front();
        exp_t e = chk_exp.pop_front();
        n_vec++;
        if ({a.vs, a.hs, a.de, a.data} !== {e.vs, e.hs, e.de, e.data}) begin
          n_err++; $display("FAIL after_reset px(%0d,%0d) got %07h want %07h", e.x, e.y, {a.vs, a.hs, a.de, a.data}, {e.vs, e.hs, e.de, e.data});
        end
        if (a.de === 1'b1 && a.data === RED) nr++;
      end
      n_vec++;
      if (nr != want_r[f]) begin n_err++; $display("FAIL after_reset_red f%0d got %0d want %0d", f, nr, want_r[f]); end
    end
  endtask

  task automatic test_wrap();
    int want_g[3] = '{4, 4, 6};
    clear_boxes();
    write_box(0, mk(1, 1, 5, 5, 6, 6, RED));
    write_box(1, mk(1, 1, TW - 2, TH - 2, TW - 1, TH - 1, GRN));
    for (int f = 0; f < 3; f++) begin
      int nr = 0, ng = 0;
      frame(f != 1, (f == 2) ? TH + 1 : TH);
      while (chk_act.size() > 0) begin
        act_t a = chk_act.pop_front();
        exp_t e = chk_exp.pop_front();
        n_vec++;
        if ({a.vs, a.hs, a.de, a.data} !== {e.vs, e.hs, e.de, e.data}) begin
          n_err++; $display("FAIL wrap f%0d px(%0d,%0d) got %07h want %07h", f, e.x, e.y, {a.vs, a.hs, a.de, a.data}, {e.vs, e.hs, e.de, e.data});
        end
        if (a.de === 1'b1 && a.data === RED) nr++;
        if (a.de === 1'b1 && a.data === GRN) ng++;
      end
      n_vec += 2;
      if (nr != 36) begin n_err++; $display("FAIL wrap_red f%0d got %0d want 36", f, nr); end
      if (ng != want_g[f]) begin n_err++; $display("FAIL wrap_green f%0d got %0d want %0d", f, ng, want_g[f]); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      for (int k = 0; k < NB; k++)
        write_box(k, mk(1'($urandom_range(0, 3) != 0), 1'($urandom), $urandom_range(0, TW), $urandom_range(0, TH),
                        $urandom_range(0, TW + 4), $urandom_range(0, TH + 4), 24'($urandom)));
      frame(1, TH);
      while (chk_act.size() > 0) begin
        act_t a = chk_act.pop_front();
        exp_t e = chk_exp.pop_front();
        n_vec++;
        if ({a.vs, a.hs, a.de, a.data} !== {e.vs, e.hs, e.de, e.data}) begin
          n_err++; $display("FAIL random r%0d px(%0d,%0d) got %07h want %07h", r, e.x, e.y, {a.vs, a.hs, a.de, a.data}, {e.vs, e.hs, e.de, e.data});
        end
      end
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    wr_flag = 0; sched_vs = 0; sched_row = -1; wr_idx = 0;
    wr_box = mk(0, 0, 0, 0, 0, 0, 24'h0);
    test_reset();
    test_outline();
    test_fill();
    test_overlap();
    test_double_buffer();
    test_edges();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
